sr_mdu: RTL and testbench

Parametrised iterative multiply/divide unit for the schoolRISCV core. It is the successor to the single-function multi-cycle unit and its handshake wrapper. It executes MUL, MULHU, DIVU and REMU over a configurable operand width using one shared shift/accumulate datapath. It stalls the core through a ready handshake, and supports flush and divide-by-zero early completion. It sits beside the ALU. The core holds PC and operands while `ready_o` is low, and writes `result_o` to the register file on the `wen_o` pulse.

---
 rtl/sr_mdu_pkg.sv | 26 ++
 rtl/sr_mdu_core.sv | 73 +++++++
 rtl/sr_mdu.sv | 98 +++++++++
 tb/tb_sr_mdu.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sr_mdu_pkg.sv
// sr_mdu shared definitions: MDU op encodings, the MULDIV funct7
// used by decode to raise the MDU request, and FSM state codes.
package sr_mdu_pkg;

    localparam logic [1:0] MDU_MUL   = 2'd0;
    localparam logic [1:0] MDU_MULHU = 2'd1;
    localparam logic [1:0] MDU_DIVU  = 2'd2;
    localparam logic [1:0] MDU_REMU  = 2'd3;

    localparam logic [6:0] RVF7_MULDIV = 7'b0000001;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // DIVU/REMU share op[1]=1
    function automatic logic isDiv(input logic [1:0] op);
        return op[1];
    endfunction

    // MULHU/REMU take the upper accumulator half
    function automatic logic isHigh(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/sr_mdu_core.sv
// sr_mdu iterative datapath: shared shift/add (MUL) and restoring
// subtract (DIV) over one 2*WIDTH accumulator, plus iteration counter.
// Ports: clk, reset (async high), load/step controls, op/a/b operands,
//        lastStep (cnt==1), stepResult (result after the current step).
module sr_mdu_core
    import sr_mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             lastStep,
    output logic [WIDTH-1:0] stepResult
);

    // acc = {hi, lo}: MUL {partial product, multiplier}
    //                 DIV {remainder, dividend->quotient}
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] accNext;
    logic [WIDTH-1:0]   opB;
    logic [1:0]         opReg;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     addSum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;

    always_comb begin
        addSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opB};
        shifted = acc[2*WIDTH-1:WIDTH-1];
        // shifted < 2*opB, so a negative difference always sets bit WIDTH
        trial   = shifted - {1'b0, opB};
        accNext = acc;
        if (isDiv(opReg)) begin
            if (trial[WIDTH])
                accNext = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                accNext = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            if (acc[0])
                accNext = {addSum, acc[WIDTH-1:1]};
            else
                accNext = {1'b0, acc[2*WIDTH-1:1]};
        end
        stepResult = isHigh(opReg) ? accNext[2*WIDTH-1:WIDTH]
                                   : accNext[WIDTH-1:0];
    end

    assign lastStep = (cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            opB   <= '0;
            opReg <= '0;
            cnt   <= '0;
        end else if (load) begin
            acc   <= {{WIDTH{1'b0}}, a};
            opB   <= b;
            opReg <= op;
            cnt   <= CNT_W'(WIDTH);
        end else if (step) begin
            acc   <= accNext;
            cnt   <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/sr_mdu.sv
// sr_mdu: iterative MUL/MULHU/DIVU/REMU unit with ready-stall handshake.
// Ports: clk_i, rst_i (async high), req_i, op_i, a_i, b_i, flush_i;
//        ready_o, busy_o, wen_o (1-cycle strobe), result_o (registered).
module sr_mdu
    import sr_mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             wen_o,
    output logic [WIDTH-1:0] result_o
);

    logic [1:0]       state;
    logic             isIdle;
    logic             isBusy;
    logic             isDone;
    logic             divZero;
    logic             load;
    logic             step;
    logic             lastStep;
    logic [WIDTH-1:0] stepResult;

    assign isIdle  = (state == ST_IDLE);
    assign isBusy  = (state == ST_BUSY);
    assign isDone  = (state == ST_DONE);
    assign divZero = isDiv(op_i) && (b_i == '0);
    assign load    = isIdle && req_i && !flush_i && !divZero;
    assign step    = isBusy && !flush_i;

    sr_mdu_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) uCore (
        .clk        (clk_i),
        .reset      (rst_i),
        .load       (load),
        .step       (step),
        .op         (op_i),
        .a          (a_i),
        .b          (b_i),
        .lastStep   (lastStep),
        .stepResult (stepResult)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            result_o <= '0;
        end else if (flush_i) begin
            state <= ST_IDLE;
        end else begin
            unique case (1'b1)
                isIdle: begin
                    if (req_i && divZero) begin
                        state    <= ST_DONE;
                        result_o <= (op_i == MDU_DIVU) ? '1 : a_i;
                    end else if (req_i) begin
                        state <= ST_BUSY;
                    end
                end
                isBusy: begin
                    if (lastStep) begin
                        state    <= ST_DONE;
                        result_o <= stepResult;
                    end
                end
                // unconditional: PC advances on this edge, so a held
                // req_i belongs to the next instruction
                isDone:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ready_o = 1'b0;
        unique case (1'b1)
            isIdle:  ready_o = ~req_i;
            isBusy:  ready_o = 1'b0;
            isDone:  ready_o = 1'b1;
            default: ready_o = 1'b0;
        endcase
    end

    assign busy_o = isBusy;
    assign wen_o  = isDone;

endmodule

// File: tb/tb_sr_mdu.sv
// Directed bench for sr_mdu at WIDTH=32 and WIDTH=8.
// Checks latency, stall, results, div-by-zero, flush and async reset.
module tb_sr_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req32, flush32;
    logic [1:0]  op32;
    logic [31:0] a32, b32;
    logic        ready32, busy32, wen32;
    logic [31:0] result32;
    logic        req8, flush8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8;
    logic        ready8, busy8, wen8;
    logic [7:0]  result8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sr_mdu #(.WIDTH(32)) dut32 (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req32),
        .op_i     (op32),
        .a_i      (a32),
        .b_i      (b32),
        .flush_i  (flush32),
        .ready_o  (ready32),
        .busy_o   (busy32),
        .wen_o    (wen32),
        .result_o (result32)
    );

    sr_mdu #(.WIDTH(8)) dut8 (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req8),
        .op_i     (op8),
        .a_i      (a8),
        .b_i      (b8),
        .flush_i  (flush8),
        .ready_o  (ready8),
        .busy_o   (busy8),
        .wen_o    (wen8),
        .result_o (result8)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref8(input logic [1:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (op)
            2'd0:    return p[7:0];
            2'd1:    return p[15:8];
            2'd2:    return (b == 0) ? 8'hFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Called just after a posedge; returns just after a posedge with req low.
    task automatic doOp(input bit w8, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int expLat,
                        input string tag);
        bit          got = 0;
        bit          badReady = 0;
        int          lat = -1;
        int          busyCnt = 0;
        logic [31:0] res = '0;
        if (w8) begin
            req8 = 1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            req32 = 1; op32 = op; a32 = a; b32 = b;
        end
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (w8 ? busy8 : busy32) busyCnt++;
            if (w8 ? wen8 : wen32) begin
                got = 1;
                lat = c;
                res = w8 ? {24'd0, result8} : result32;
                if (!(w8 ? ready8 : ready32)) badReady = 1;
                break;
            end
            if (w8 ? ready8 : ready32) badReady = 1;
            @(posedge clk); #1;
            // latched copies must be used, not live operands
            if (c == 0) begin
                if (w8) begin
                    a8 = 8'($urandom); b8 = 8'($urandom);
                end else begin
                    a32 = $urandom; b32 = $urandom;
                end
            end
        end
        @(posedge clk); #1;
        req8  = 0;
        req32 = 0;
        chk({tag, " done"}, 64'(got), 64'd1);
        chk({tag, " lat"}, 64'(lat), 64'(expLat));
        chk({tag, " res"}, 64'(res), 64'(exp));
        chk({tag, " busy"}, 64'(busyCnt), 64'(expLat - 1));
        chk({tag, " stall"}, 64'(badReady), 64'd0);
        @(negedge clk);
        chk({tag, " onewen"}, 64'(w8 ? wen8 : wen32), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int wenCnt;
        logic [1:0] rop;
        logic [7:0] ra, rb;
        rst = 1; req32 = 0; flush32 = 0; op32 = 0; a32 = 0; b32 = 0;
        req8 = 0; flush8 = 0; op8 = 0; a8 = 0; b8 = 0;

        @(negedge clk);
        chk("rst ready", 64'(ready32), 64'd1);
        chk("rst busy", 64'(busy32), 64'd0);
        chk("rst wen", 64'(wen32), 64'd0);
        chk("rst result", 64'(result32), 64'd0);
        req32 = 1; #1;
        chk("rst ready req", 64'(ready32), 64'd0);
        req32 = 0;
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        doOp(0, 2'd0, 32'd7, 32'd6, 32'd42, 33, "mul7x6");
        doOp(0, 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu");
        doOp(0, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 33, "mulff");
        doOp(0, 2'd2, 32'd100, 32'd7, 32'd14, 33, "divu");
        doOp(0, 2'd3, 32'd100, 32'd7, 32'd2, 33, "remu");
        doOp(0, 2'd2, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "divu0");
        doOp(0, 2'd3, 32'd5, 32'd0, 32'd5, 1, "remu0");

        // flush in cycle 10 of MUL 3x3
        req32 = 1; op32 = 2'd0; a32 = 3; b32 = 3;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("flush pre busy", 64'(busy32), 64'd1);
        flush32 = 1; req32 = 0;
        @(posedge clk); #1;
        flush32 = 0;
        @(negedge clk);
        chk("flush busy", 64'(busy32), 64'd0);
        chk("flush wen", 64'(wen32), 64'd0);
        chk("flush result", 64'(result32), 64'd5);
        chk("flush ready", 64'(ready32), 64'd1);
        wenCnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (wen32) wenCnt++;
        end
        chk("flush nowen", 64'(wenCnt), 64'd0);
        @(posedge clk); #1;
        doOp(0, 2'd0, 32'd3, 32'd3, 32'd9, 33, "mul3x3");

        // async reset mid-BUSY
        req32 = 1; op32 = 2'd0; a32 = 7; b32 = 6;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("prerst busy", 64'(busy32), 64'd1);
        #2 rst = 1;
        #1;
        chk("arst busy", 64'(busy32), 64'd0);
        chk("arst wen", 64'(wen32), 64'd0);
        chk("arst result", 64'(result32), 64'd0);
        req32 = 0;
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        // WIDTH=8 sweep
        doOp(1, 2'd0, 32'd255, 32'd255, 32'h01, 9, "w8 mulff");
        doOp(1, 2'd1, 32'd255, 32'd255, 32'hFE, 9, "w8 mulhuff");
        doOp(1, 2'd2, 32'd255, 32'd1, 32'd255, 9, "w8 div1");
        doOp(1, 2'd3, 32'd200, 32'd13, 32'd5, 9, "w8 rem13");
        for (int i = 0; i < 16; i++) begin
            rop = 2'(i % 4);
            ra  = 8'($urandom);
            rb  = 8'($urandom_range(1, 255));
            doOp(1, rop, 32'(ra), 32'(rb), 32'(ref8(rop, ra, rb)), 9,
                 $sformatf("w8 rnd%0d", i));
        end
        doOp(1, 2'd2, 32'd9, 32'd0, 32'(ref8(2'd2, 8'd9, 8'd0)), 1, "w8 div0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
